spi_cmd_controller: RTL and testbench
=====================================

SPI_CMD_CONTROLLER -- requirements
Module: spi_cmd_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: idle cycles allowed between bytes of one command.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port spi_cs_n  input  1  raw SPI chip select, active-low, asynchronous to clk.
REQ-005 SHALL have port rx_data  input  8  received byte from the SPI slave.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port npu_busy  input  1  NPU core busy.
REQ-008 SHALL have port reg_wr_en  output  1  one-cycle register write strobe.
REQ-009 SHALL have port reg_addr  output  8  register write address.
REQ-010 SHALL have port reg_wdata  output  8  register write data.
REQ-011 SHALL have port npu_start  output  1  one-cycle NPU start pulse.
REQ-012 SHALL have port cmd_err  output  1  sticky error flag.
REQ-013 SHALL have port cmd_cnt  output  8  count of successfully executed commands.

Function
REQ-014 SHALL synchronize spi_cs_n through two flops (reset value 1); "frame active" means the synchronized value is 0.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DATA, DISCARD.
REQ-016 SHALL move IDLE->CMD when frame active.
REQ-017 SHALL move any state->IDLE when frame inactive; a partial WRITE (in ADDR or DATA) aborts with no write and sets cmd_err.
REQ-018 SHALL, in CMD with rx_valid, decode opcodes: 0xA0 WRITE->ADDR; 0xB0 START; 0xC0 CLEAR; any other value sets cmd_err and moves to DISCARD.
REQ-019 SHALL, for START: pulse npu_start the next cycle if npu_busy=0, else set cmd_err and not pulse; stay in CMD.
REQ-020 SHALL, for CLEAR: clear cmd_err the next cycle; stay in CMD.
REQ-021 SHALL latch rx_data into reg_addr on rx_valid in ADDR, then go to DATA.
REQ-022 SHALL, on rx_valid in DATA, load reg_wdata and pulse reg_wr_en the next cycle (latency 1 from the last byte), then go to CMD.
REQ-023 SHALL hold reg_addr and reg_wdata stable between writes.
REQ-024 SHALL ignore rx_valid in IDLE and DISCARD.
REQ-025 SHALL, if rx_valid and frame deassertion coincide, process the byte first (a command completed by it executes), then enter IDLE.
REQ-026 SHALL increment cmd_cnt by 1 on each executed WRITE, START (not blocked by npu_busy) or CLEAR, wrapping 255->0.
REQ-027 SHALL let a new error in the same cycle as CLEAR win (cmd_err stays 1).
REQ-028 SHALL allow multiple commands per frame with no gaps required.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: state IDLE; reg_wr_en 0; npu_start 0; reg_addr 0x00; reg_wdata 0x00; cmd_err 0; cmd_cnt 0x00; timeout counter 0.
REQ-030 SHALL, when reset is asserted mid-command, issue no write or start pulse afterwards; after release it SHALL await a fresh frame (CS synchronizer at 1).

Configuration
REQ-031 SHALL compile the inter-byte timeout only when macro SPI_CMD_TIMEOUT_EN is defined.
REQ-032 SHALL, with SPI_CMD_TIMEOUT_EN defined: count cycles in ADDR/DATA, cleared on rx_valid or state entry; on reaching TIMEOUT_CYCLES, set cmd_err and move to DISCARD.
REQ-033 SHALL, without SPI_CMD_TIMEOUT_EN, contain no timeout counter; ADDR/DATA wait indefinitely while the frame is active.

Verification
REQ-034 SHALL verify: frame with bytes A0,12,5A -> one reg_wr_en pulse, reg_addr=0x12, reg_wdata=0x5A, cmd_cnt=1.
REQ-035 SHALL verify: B0 with npu_busy=0 -> one npu_start pulse; B0 with npu_busy=1 -> no pulse, cmd_err=1; then C0 -> cmd_err=0.
REQ-036 SHALL verify: byte 0x77 then A0,01,02 in the same frame -> cmd_err=1, no reg_wr_en until CS high; a new frame with A0,01,02 writes.
REQ-037 SHALL verify: A0,34 then CS high -> no write, cmd_err=1, state IDLE.
REQ-038 SHALL verify: 256 back-to-back WRITEs -> cmd_cnt wraps to 0x00.
REQ-039 SHALL verify: with SPI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, A0 then 16 idle cycles -> cmd_err=1, a late byte is ignored.

Source files
------------

// File: rtl/spi_cmd_controller.sv
// SPI command decoder: WRITE (A0 addr data), START (B0), CLEAR (C0) into register/NPU strobes.
// Optional inter-byte timeout is compiled in with `define SPI_CMD_TIMEOUT_EN.
module spi_cmd_controller #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       npu_busy,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       npu_start,
  output logic       cmd_err,
  output logic [7:0] cmd_cnt
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DISCARD} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_cs_meta, r_cs_sync;
  logic       r_wr_en, r_start, r_err;
  logic [7:0] r_addr, r_wdata, r_cnt;
  logic       w_frame, w_tmo;
  logic       w_wr, w_start, w_inc, w_err_set, w_err_clr, w_addr_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
    end else begin
      r_cs_meta <= spi_cs_n;
      r_cs_sync <= r_cs_meta;
    end
  end

  assign w_frame = ~r_cs_sync;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_in_wait;

  assign w_in_wait = (r_state == ADDR) || (r_state == DATA);

  // Counts consecutive idle cycles inside a WRITE; restarts on every byte and state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo_cnt <= '0;
    else if (!w_in_wait || rx_valid || (w_state_nxt != r_state))
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo = w_in_wait && !rx_valid && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_start     = 1'b0;
    w_inc       = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_addr_ld   = 1'b0;
    case (r_state)
      IDLE: if (w_frame) w_state_nxt = CMD;
      CMD: if (rx_valid) begin
        case (rx_data)
          8'hA0: w_state_nxt = ADDR;
          8'hB0: begin
            if (!npu_busy) begin
              w_start = 1'b1;
              w_inc   = 1'b1;
            end else begin
              w_err_set = 1'b1;
            end
          end
          8'hC0: begin
            w_err_clr = 1'b1;
            w_inc     = 1'b1;
          end
          default: begin
            w_err_set   = 1'b1;
            w_state_nxt = DISCARD;
          end
        endcase
      end
      ADDR: begin
        if (rx_valid) begin
          w_addr_ld   = 1'b1;
          w_state_nxt = DATA;
        end else if (w_tmo) begin
          w_err_set   = 1'b1;
          w_state_nxt = DISCARD;
        end
      end
      DATA: begin
        if (rx_valid) begin
          w_wr        = 1'b1;
          w_inc       = 1'b1;
          w_state_nxt = CMD;
        end else if (w_tmo) begin
          w_err_set   = 1'b1;
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: ;
      default: w_state_nxt = IDLE;
    endcase
    // Frame end overrides, after the coincident byte has been decoded; an unfinished WRITE is an error.
    if (!w_frame && (r_state != IDLE)) begin
      if ((w_state_nxt == ADDR) || (w_state_nxt == DATA)) w_err_set = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wr_en <= 1'b0;
      r_start <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_err   <= 1'b0;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr;
      r_start <= w_start;
      if (w_addr_ld) r_addr <= rx_data;
      if (w_wr)      r_wdata <= rx_data;
      r_err <= (r_err & ~w_err_clr) | w_err_set;
      if (w_inc)     r_cnt <= r_cnt + 8'd1;
    end
  end

  assign reg_wr_en = r_wr_en;
  assign npu_start = r_start;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign cmd_err   = r_err;
  assign cmd_cnt   = r_cnt;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: per-cycle vector table plus reset, wrap and timeout sequences.
module tb_spi_cmd_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       npu_busy = 1'b0;
  logic       reg_wr_en, npu_start, cmd_err;
  logic [7:0] reg_addr, reg_wdata, cmd_cnt;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_st = 0;

  always #5 clk = ~clk;

  spi_cmd_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .npu_busy(npu_busy), .reg_wr_en(reg_wr_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .npu_start(npu_start),
    .cmd_err(cmd_err), .cmd_cnt(cmd_cnt)
  );

  typedef struct {
    logic       cs_n, vld, busy;
    logic [7:0] d;
    logic       wr, st, err;
    logic [7:0] addr, wdata, cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cs_n, input logic vld, input logic [7:0] d, input logic busy,
                     input logic wr, input logic st, input logic err,
                     input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] cnt);
    vec_t v;
    v.cs_n = cs_n; v.vld = vld; v.d = d; v.busy = busy;
    v.wr = wr; v.st = st; v.err = err; v.addr = addr; v.wdata = wdata; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic cs_n, input logic vld, input logic [7:0] d, input logic busy);
    spi_cs_n = cs_n; rx_valid = vld; rx_data = d; npu_busy = busy;
    @(posedge clk);
    #1;
    if (reg_wr_en) n_wr++;
    if (npu_start) n_st++;
  endtask

  initial begin
    // cs,vld,data,busy | wr,st,err,addr,wdata,cnt
    add(1,0,8'h00,0, 0,0,0,8'h00,8'h00,8'h00);
    repeat (3) add(0,0,8'h00,0, 0,0,0,8'h00,8'h00,8'h00);
    add(0,1,8'hA0,0, 0,0,0,8'h00,8'h00,8'h00);
    add(0,1,8'h12,0, 0,0,0,8'h12,8'h00,8'h00);
    add(0,1,8'h5A,0, 1,0,0,8'h12,8'h5A,8'h01);
    add(0,0,8'h00,0, 0,0,0,8'h12,8'h5A,8'h01);
    add(0,1,8'hB0,0, 0,1,0,8'h12,8'h5A,8'h02);
    add(0,0,8'h00,0, 0,0,0,8'h12,8'h5A,8'h02);
    add(0,1,8'hB0,1, 0,0,1,8'h12,8'h5A,8'h02);
    add(0,1,8'hC0,0, 0,0,0,8'h12,8'h5A,8'h03);
    add(0,1,8'h77,0, 0,0,1,8'h12,8'h5A,8'h03);
    add(0,1,8'hA0,0, 0,0,1,8'h12,8'h5A,8'h03);
    add(0,1,8'h01,0, 0,0,1,8'h12,8'h5A,8'h03);
    add(0,1,8'h02,0, 0,0,1,8'h12,8'h5A,8'h03);
    repeat (3) add(1,0,8'h00,0, 0,0,1,8'h12,8'h5A,8'h03);
    repeat (3) add(0,0,8'h00,0, 0,0,1,8'h12,8'h5A,8'h03);
    add(0,1,8'hA0,0, 0,0,1,8'h12,8'h5A,8'h03);
    add(0,1,8'h01,0, 0,0,1,8'h01,8'h5A,8'h03);
    add(0,1,8'h02,0, 1,0,1,8'h01,8'h02,8'h04);
    add(0,1,8'hC0,0, 0,0,0,8'h01,8'h02,8'h05);
    add(0,1,8'hA0,0, 0,0,0,8'h01,8'h02,8'h05);
    add(0,1,8'h34,0, 0,0,0,8'h34,8'h02,8'h05);
    repeat (2) add(1,0,8'h00,0, 0,0,0,8'h34,8'h02,8'h05);
    repeat (2) add(1,0,8'h00,0, 0,0,1,8'h34,8'h02,8'h05);
    repeat (3) add(0,0,8'h00,0, 0,0,1,8'h34,8'h02,8'h05);
    add(0,1,8'hC0,0, 0,0,0,8'h34,8'h02,8'h06);
    add(0,1,8'hA0,0, 0,0,0,8'h34,8'h02,8'h06);
    add(0,1,8'h55,0, 0,0,0,8'h55,8'h02,8'h06);
    repeat (2) add(1,0,8'h00,0, 0,0,0,8'h55,8'h02,8'h06);
    add(1,1,8'h66,0, 1,0,0,8'h55,8'h66,8'h07);
    add(1,0,8'h00,0, 0,0,0,8'h55,8'h66,8'h07);
    add(1,1,8'hB0,0, 0,0,0,8'h55,8'h66,8'h07);
    add(1,1,8'h77,0, 0,0,0,8'h55,8'h66,8'h07);

    #2;
    chk("rst wr_en", reg_wr_en, 0);
    chk("rst start", npu_start, 0);
    chk("rst err",   cmd_err,   0);
    chk("rst addr",  reg_addr,  0);
    chk("rst wdata", reg_wdata, 0);
    chk("rst cnt",   cmd_cnt,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].cs_n, tbl[i].vld, tbl[i].d, tbl[i].busy);
      chk($sformatf("v%0d wr_en", i), reg_wr_en, tbl[i].wr);
      chk($sformatf("v%0d start", i), npu_start, tbl[i].st);
      chk($sformatf("v%0d err",   i), cmd_err,   tbl[i].err);
      chk($sformatf("v%0d addr",  i), reg_addr,  tbl[i].addr);
      chk($sformatf("v%0d wdata", i), reg_wdata, tbl[i].wdata);
      chk($sformatf("v%0d cnt",   i), cmd_cnt,   tbl[i].cnt);
    end

    // Reset asserted mid-WRITE: outputs clear at once, no strobe follows.
    repeat (3) step(0, 0, 8'h00, 0);
    step(0, 1, 8'hA0, 0);
    step(0, 1, 8'h11, 0);
    rx_valid = 1'b1; rx_data = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst addr", reg_addr, 0);
    chk("midrst cnt",  cmd_cnt,  0);
    chk("midrst err",  cmd_err,  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_wr = 0; n_st = 0;
    repeat (6) step(1, 0, 8'h00, 0);
    chk("midrst no wr", n_wr, 0);
    chk("midrst no st", n_st, 0);
    chk("midrst wdata", reg_wdata, 0);

    // 256 back-to-back WRITEs in one frame: counter wraps to zero.
    repeat (3) step(0, 0, 8'h00, 0);
    n_wr = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 8'hA0, 0);
      step(0, 1, 8'(i), 0);
      step(0, 1, 8'(255 - i), 0);
      if (i == 254) chk("wrap cnt255", cmd_cnt, 8'hFF);
    end
    chk("wrap pulses", n_wr, 256);
    chk("wrap cnt0",   cmd_cnt, 8'h00);
    chk("wrap addr",   reg_addr, 8'hFF);
    chk("wrap wdata",  reg_wdata, 8'h00);
    chk("wrap err",    cmd_err, 0);
    repeat (4) step(1, 0, 8'h00, 0);

`ifdef SPI_CMD_TIMEOUT_EN
    // 16 idle cycles after A0 trip the timeout; later bytes are discarded.
    repeat (3) step(0, 0, 8'h00, 0);
    step(0, 1, 8'hA0, 0);
    repeat (15) step(0, 0, 8'h00, 0);
    chk("tmo err@15", cmd_err, 0);
    step(0, 0, 8'h00, 0);
    chk("tmo err@16", cmd_err, 1);
    n_wr = 0;
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    step(0, 0, 8'h00, 0);
    chk("tmo no wr", n_wr, 0);
    chk("tmo addr",  reg_addr, 8'hFF);
    chk("tmo cnt",   cmd_cnt, 8'h00);
    repeat (4) step(1, 0, 8'h00, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
